rotate_sched: RTL and testbench

//  Shares the single rotate datapath (sincos + 2x2 multiply, 1-cycle registered

---
 rtl/rotate_sched.sv | 148 ++++++++++++++
 tb/tb_rotate_sched.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rotate_sched.sv
// Round-robin scheduler that shares one rotate datapath between NREQ point requesters.
// Keeps rot_angle constant while tagged points are in flight and switches it only between frames.
module rotate_sched #(
   parameter int unsigned NREQ   = 3,
   parameter int unsigned IDW    = 2,
   parameter int unsigned LAT    = 1,
   parameter int unsigned SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 frame_start,
   input  logic [9:0]           angle_i,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*10-1:0]   req_x,
   input  logic [NREQ*10-1:0]   req_y,
   output logic [NREQ-1:0]      req_ready,
   output logic [9:0]           rot_angle,
   output logic [9:0]           rot_x,
   output logic [9:0]           rot_y,
   input  logic [9:0]           rot_xo,
   input  logic [9:0]           rot_yo,
   output logic                 res_valid,
   output logic [IDW-1:0]       res_id,
   output logic [9:0]           res_x,
   output logic [9:0]           res_y,
   output logic                 busy
);

   localparam int unsigned DW = 10;
   localparam int unsigned CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SETTLE} state_t;

   state_t            state_q, state_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [DW-1:0]     angle_q, angle_d;
   logic [DW-1:0]     rot_angle_q, rot_angle_d;
   logic [DW-1:0]     last_x_q, last_y_q;
   logic [LAT-1:0]    tag_v_q;
   logic [IDW-1:0]    tag_id_q [LAT];
   logic              busy_q;

   logic              gnt_found;
   logic [IDW-1:0]    gnt_idx;
   logic              gnt;
   logic              tag_any;

   // Lowest-index valid requester at or after the pointer, wrapping
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (!gnt_found && req_valid[(32'(ptr_q) + i) % NREQ]) begin
            gnt_found = 1'b1;
            gnt_idx   = IDW'((32'(ptr_q) + i) % NREQ);
         end
      end
   end

   // Grants only in RUN; the frame_start cycle itself is suppressed
   assign gnt       = rst_n && (state_q == ST_RUN) && !frame_start && gnt_found;
   assign req_ready = gnt ? (NREQ'(1) << gnt_idx) : '0;
   assign rot_x     = gnt ? req_x[DW*32'(gnt_idx) +: DW] : last_x_q;
   assign rot_y     = gnt ? req_y[DW*32'(gnt_idx) +: DW] : last_y_q;

   assign ptr_d     = !gnt ? ptr_q :
                      (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);
   assign tag_any   = |tag_v_q;

   // Frame-switch sequencing and angle latch
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      angle_d     = angle_q;
      rot_angle_d = rot_angle_q;
      if (frame_start) begin
         angle_d = angle_i;
      end
      case (state_q)
         ST_RUN: begin
            if (frame_start) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!tag_any) begin
               rot_angle_d = frame_start ? angle_i : angle_q;
               cnt_d       = CW'(SETTLE);
               state_d     = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (frame_start) begin
               state_d = ST_DRAIN;
            end else if (cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         ptr_q       <= '0;
         cnt_q       <= '0;
         angle_q     <= '0;
         rot_angle_q <= '0;
         last_x_q    <= '0;
         last_y_q    <= '0;
         busy_q      <= 1'b0;
         tag_v_q     <= '0;
         for (int unsigned i = 0; i < LAT; i++) begin
            tag_id_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         angle_q     <= angle_d;
         rot_angle_q <= rot_angle_d;
         busy_q      <= (state_d != ST_RUN);
         if (gnt) begin
            last_x_q <= rot_x;
            last_y_q <= rot_y;
         end
         // Tag pipeline mirrors the datapath latency
         for (int unsigned i = LAT - 1; i > 0; i--) begin
            tag_v_q[i]  <= tag_v_q[i-1];
            tag_id_q[i] <= tag_id_q[i-1];
         end
         tag_v_q[0]  <= gnt;
         tag_id_q[0] <= gnt_idx;
      end
   end

   assign rot_angle = rot_angle_q;
   assign res_valid = tag_v_q[LAT-1];
   assign res_id    = tag_id_q[LAT-1];
   assign res_x     = rot_xo;
   assign res_y     = rot_yo;
   assign busy      = busy_q;

endmodule

// File: tb/tb_rotate_sched.sv
// Directed bench for rotate_sched: round robin table, frame switches, mid-flight reset.
// The rotate stand-in registers x+angle / y-angle so results reveal which angle was used.
module tb_rotate_sched;

   localparam int unsigned NREQ = 3;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                frame_start;
   logic [9:0]          angle_i;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*10-1:0]  req_x, req_y;
   logic [NREQ-1:0]     req_ready;
   logic [9:0]          rot_angle, rot_x, rot_y;
   logic [9:0]          rot_xo, rot_yo;
   logic                res_valid;
   logic [1:0]          res_id;
   logic [9:0]          res_x, res_y;
   logic                busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rotate_sched #(.NREQ(3), .IDW(2), .LAT(1), .SETTLE(1)) dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .angle_i(angle_i),
      .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
      .rot_angle(rot_angle), .rot_x(rot_x), .rot_y(rot_y),
      .rot_xo(rot_xo), .rot_yo(rot_yo),
      .res_valid(res_valid), .res_id(res_id), .res_x(res_x), .res_y(res_y),
      .busy(busy)
   );

   always @(posedge clk) begin
      rot_xo <= rot_x + rot_angle;
      rot_yo <= rot_y - rot_angle;
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   function automatic int idx_of(input logic [2:0] r);
      for (int k = 0; k < 3; k++) if (r[k]) return k;
      return 0;
   endfunction

   typedef struct {
      logic [2:0] v;
      logic [2:0] rdy;
   } vec_t;

   vec_t tbl [14];
   int   xs [3];
   int   ys [3];

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      int prev_v, prev_id, last_x, n;
      tbl[0]  = '{3'b111, 3'b001};
      tbl[1]  = '{3'b111, 3'b010};
      tbl[2]  = '{3'b111, 3'b100};
      tbl[3]  = '{3'b111, 3'b001};
      tbl[4]  = '{3'b111, 3'b010};
      tbl[5]  = '{3'b111, 3'b100};
      tbl[6]  = '{3'b010, 3'b010};
      tbl[7]  = '{3'b000, 3'b000};
      tbl[8]  = '{3'b001, 3'b001};
      tbl[9]  = '{3'b101, 3'b100};
      tbl[10] = '{3'b110, 3'b010};
      tbl[11] = '{3'b011, 3'b001};
      tbl[12] = '{3'b100, 3'b100};
      tbl[13] = '{3'b000, 3'b000};
      xs[0] = 11;   ys[0] = -11;
      xs[1] = 100;  ys[1] = -50;
      xs[2] = -300; ys[2] = 7;
      for (int k = 0; k < 3; k++) begin
         req_x[k*10 +: 10] = 10'(xs[k]);
         req_y[k*10 +: 10] = 10'(ys[k]);
      end

      // Reset with every requester asserting
      rst_n = 1'b0; frame_start = 1'b0; angle_i = '0; req_valid = 3'b111;
      repeat (3) begin
         @(negedge clk);
         chk("rst_res_valid", res_valid, 0);
         chk("rst_rot_angle", rot_angle, 0);
         chk("rst_req_ready", req_ready, 0);
         chk("rst_busy", busy, 0);
      end
      rst_n = 1'b1;

      // Round robin and pass-through at angle 0
      prev_v = 0; prev_id = 0; last_x = 0;
      for (int i = 0; i < 14; i++) begin
         if (i > 0) @(negedge clk);
         req_valid = tbl[i].v;
         #1;
         chk($sformatf("rr_ready[%0d]", i), req_ready, tbl[i].rdy);
         chk($sformatf("rr_res_valid[%0d]", i), res_valid, prev_v);
         if (prev_v != 0) begin
            chk($sformatf("rr_res_id[%0d]", i), res_id, prev_id);
            chk($sformatf("rr_res_x[%0d]", i), $signed(res_x), xs[prev_id]);
            chk($sformatf("rr_res_y[%0d]", i), $signed(res_y), ys[prev_id]);
         end
         if (tbl[i].rdy != 3'b000) last_x = xs[idx_of(tbl[i].rdy)];
         chk($sformatf("rr_rot_x[%0d]", i), $signed(rot_x), last_x);
         prev_v  = (tbl[i].rdy != 3'b000) ? 1 : 0;
         prev_id = idx_of(tbl[i].rdy);
      end

      // Frame switch to 256 under continuous req0
      @(negedge clk); req_valid = 3'b001; #1;
      chk("fs_pre_ready", req_ready, 3'b001);
      @(negedge clk); frame_start = 1'b1; angle_i = 10'd256; #1;
      chk("fs_suppress", req_ready, 0);
      chk("fs_old_valid", res_valid, 1);
      chk("fs_old_x", $signed(res_x), 11);
      chk("fs_old_y", $signed(res_y), -11);
      @(negedge clk); frame_start = 1'b0; angle_i = '0;
      n = 0;
      while (n < 20) begin
         #1;
         if (req_ready != 0) break;
         chk("fs_busy", busy, 1);
         chk("fs_no_res", res_valid, 0);
         if (n == 0) chk("fs_angle_held", rot_angle, 0);
         if (n == 1) chk("fs_angle_new", rot_angle, 256);
         n++;
         @(negedge clk);
      end
      chk("fs_gap", n, 3);
      chk("fs_busy_off", busy, 0);
      @(negedge clk); #1;
      chk("fs_new_valid", res_valid, 1);
      chk("fs_new_id", res_id, 0);
      chk("fs_new_x", $signed(res_x), 267);
      chk("fs_new_y", $signed(res_y), -267);

      // Back-to-back frame_start: 16 then 32, two cycles apart
      @(negedge clk); frame_start = 1'b1; angle_i = 10'd16; #1;
      chk("b2b_suppress", req_ready, 0);
      chk("b2b_last_x", $signed(res_x), 267);
      @(negedge clk); frame_start = 1'b0; #1;
      chk("b2b_drain_ready", req_ready, 0);
      chk("b2b_drain_res", res_valid, 0);
      @(negedge clk); frame_start = 1'b1; angle_i = 10'd32; #1;
      chk("b2b_angle16", rot_angle, 16);
      chk("b2b_settle_ready", req_ready, 0);
      chk("b2b_settle_res", res_valid, 0);
      @(negedge clk); frame_start = 1'b0; angle_i = '0;
      n = 0;
      while (n < 20) begin
         #1;
         if (req_ready != 0) break;
         chk("b2b_no_res", res_valid, 0);
         n++;
         @(negedge clk);
      end
      chk("b2b_gap", n, 3);
      chk("b2b_angle32", rot_angle, 32);
      @(negedge clk); #1;
      chk("b2b_res_valid", res_valid, 1);
      chk("b2b_res_x", $signed(res_x), 43);
      chk("b2b_res_y", $signed(res_y), -43);

      // Reset with a point in flight: its result must never appear
      @(posedge clk); #1; rst_n = 1'b0;
      @(negedge clk);
      chk("mrst_res_valid", res_valid, 0);
      chk("mrst_rot_angle", rot_angle, 0);
      chk("mrst_busy", busy, 0);
      @(negedge clk); rst_n = 1'b1; req_valid = 3'b010; #1;
      chk("mrst_ready", req_ready, 3'b010);
      chk("mrst_dropped", res_valid, 0);
      @(negedge clk); req_valid = 3'b000; #1;
      chk("mrst_res_valid2", res_valid, 1);
      chk("mrst_res_id", res_id, 1);
      chk("mrst_res_x", $signed(res_x), 100);
      chk("mrst_res_y", $signed(res_y), -50);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
